// File: rtl/oversample_data_recovery.sv
// ============================================================================
// Module   : oversample_data_recovery
// Brief    : Oversampled serial bit recovery with a vote/hysteresis phase loop
//            that emits 0, 1 or 2 bits per clock to absorb phase wrap.
//            Optional macro ODR_SLIP_STATS_EN adds drop/dup slip counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oversample_data_recovery #(
  parameter int NUM_PHASES  = 4,
  parameter int VOTE_THRESH = 4,
  parameter int LOCK_WINDOW = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PHASES-1:0]         in_samples,
  output logic [1:0]                    out_data,
  output logic [1:0]                    out_count,
  output logic [$clog2(NUM_PHASES)-1:0] out_phase,
`ifdef ODR_SLIP_STATS_EN
  output logic [15:0]                   out_drop_cnt,
  output logic [15:0]                   out_dup_cnt,
`endif
  output logic                          out_locked
);

  localparam int PW  = $clog2(NUM_PHASES);
  localparam int LCW = $clog2(LOCK_WINDOW + 1);
  localparam logic [PW-1:0]     c_HALF    = PW'(NUM_PHASES / 2);
  localparam logic [PW-1:0]     c_PONE    = PW'(1);
  localparam logic [PW:0]       c_CONE    = (PW+1)'(1);
  localparam logic [LCW-1:0]    c_LOCKMAX = LCW'(LOCK_WINDOW);
  localparam logic signed [7:0] c_THR     = 8'(VOTE_THRESH);
  localparam logic signed [7:0] c_NTHR    = -c_THR;

  logic [NUM_PHASES-1:0] r_word;
  logic                  r_s1_valid;
  logic                  r_prev_last;
  logic [PW-1:0]         r_phase;
  logic signed [7:0]     r_acc;
  logic [LCW-1:0]        r_lock_cnt;
  logic                  r_late_wrap;
  logic                  r_early_wrap;
  logic [1:0]            r_data;
  logic [1:0]            r_count;
  logic                  r_locked;

  logic [NUM_PHASES-1:0] w_edges;
  logic [PW-1:0]         w_q;
  logic [PW:0]           w_late;
  logic [PW:0]           w_early;
  logic                  w_ambig;
  logic signed [7:0]     w_acc_sum;
  logic                  w_inc;
  logic                  w_dec;
  logic [LCW-1:0]        w_lock_nxt;
  logic [1:0]            w_data;
  logic [1:0]            w_count;

  assign w_edges = r_word ^ {r_word[NUM_PHASES-2:0], r_prev_last};
  assign w_q     = r_phase + c_HALF;

  // Edge distance from the expected edge phase decides the vote direction.
  always_comb begin : p_vote
    logic [PW-1:0] w_d;
    w_late  = '0;
    w_early = '0;
    w_ambig = 1'b0;
    w_d     = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      w_d = PW'(i) - w_q;
      if (w_edges[i] && (w_d != '0)) begin
        if (w_d == c_HALF)     w_ambig = 1'b1;
        else if (w_d < c_HALF) w_late  = w_late + c_CONE;
        else                   w_early = w_early + c_CONE;
      end
    end
  end

  always_comb begin
    w_acc_sum = r_acc;
    if (w_late > w_early)      w_acc_sum = r_acc + 8'sd1;
    else if (w_early > w_late) w_acc_sum = r_acc - 8'sd1;
    w_inc = (w_acc_sum == c_THR);
    w_dec = (w_acc_sum == c_NTHR);

    w_lock_nxt = r_lock_cnt;
    if (w_inc || w_dec || w_ambig)             w_lock_nxt = '0;
    else if ((|w_edges) && (r_lock_cnt != c_LOCKMAX)) w_lock_nxt = r_lock_cnt + LCW'(1);

    // A pending wrap from the previous word overrides the normal single bit.
    w_count = 2'd1;
    w_data  = {1'b0, r_word[r_phase]};
    if (r_late_wrap) begin
      w_count = 2'd0;
      w_data  = 2'b00;
    end else if (r_early_wrap) begin
      w_count = 2'd2;
      w_data  = {r_word[NUM_PHASES-1], r_prev_last};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_s1_valid   <= 1'b0;
      r_prev_last  <= 1'b0;
      r_phase      <= '0;
      r_acc        <= '0;
      r_lock_cnt   <= '0;
      r_late_wrap  <= 1'b0;
      r_early_wrap <= 1'b0;
      r_data       <= '0;
      r_count      <= '0;
      r_locked     <= 1'b0;
    end else begin
      r_word     <= in_samples;
      r_s1_valid <= 1'b1;
      if (r_s1_valid) begin
        r_prev_last  <= r_word[NUM_PHASES-1];
        r_data       <= w_data;
        r_count      <= w_count;
        r_lock_cnt   <= w_lock_nxt;
        r_locked     <= (w_lock_nxt == c_LOCKMAX);
        r_late_wrap  <= w_inc && (&r_phase);
        r_early_wrap <= w_dec && (r_phase == '0);
        if (w_inc) begin
          r_phase <= r_phase + c_PONE;
          r_acc   <= '0;
        end else if (w_dec) begin
          r_phase <= r_phase - c_PONE;
          r_acc   <= '0;
        end else begin
          r_acc   <= w_acc_sum;
        end
      end
    end
  end

`ifdef ODR_SLIP_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_dup_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_dup_cnt  <= '0;
    end else if (r_s1_valid) begin
      if ((w_count == 2'd0) && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if ((w_count == 2'd2) && (r_dup_cnt != 16'hFFFF))  r_dup_cnt  <= r_dup_cnt + 16'd1;
    end
  end

  assign out_drop_cnt = r_drop_cnt;
  assign out_dup_cnt  = r_dup_cnt;
`endif

  assign out_data   = r_data;
  assign out_count  = r_count;
  assign out_phase  = r_phase;
  assign out_locked = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_oversample_data_recovery.sv
// ============================================================================
// Module   : tb_oversample_data_recovery
// Brief    : Directed self-checking bench for oversample_data_recovery (N=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oversample_data_recovery;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_samples;
  logic [1:0] out_data;
  logic [1:0] out_count;
  logic [1:0] out_phase;
  logic       out_locked;
`ifdef ODR_SLIP_STATS_EN
  logic [15:0] out_drop_cnt;
  logic [15:0] out_dup_cnt;
`endif

  int errors = 0;
  int checks = 0;

  oversample_data_recovery #(
    .NUM_PHASES (4),
    .VOTE_THRESH(4),
    .LOCK_WINDOW(64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_samples  (in_samples),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_phase   (out_phase),
`ifdef ODR_SLIP_STATS_EN
    .out_drop_cnt(out_drop_cnt),
    .out_dup_cnt (out_dup_cnt),
`endif
    .out_locked  (out_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word is captured at the next rising edge; sampling is 1ns after it.
  task automatic drive(input logic [3:0] w);
    in_samples = w;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n      = 1'b0;
    in_samples = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_samples = 4'($urandom);
    repeat (3) begin
      @(posedge clk);
      in_samples = 4'($urandom);
    end
    #1;
    checks++;
    if (out_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
    checks++;
    if (out_phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", out_phase); end
    checks++;
    if (out_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", out_locked); end
    checks++;
    if (out_data !== 2'b00) begin errors++; $display("FAIL reset_data: got %b want 00", out_data); end
    rst_n = 1'b1;
    drive(4'b1100);
    checks++;
    if (out_count !== 2'd0) begin errors++; $display("FAIL release_latency1: got count %0d want 0", out_count); end
    drive(4'b0011);
    checks++;
    if (out_count !== 2'd1) begin errors++; $display("FAIL release_latency2: got count %0d want 1", out_count); end
    checks++;
    if (out_data !== 2'b00) begin errors++; $display("FAIL release_data: got %b want 00", out_data); end
  endtask

  // Edges always at the expected position: no votes, lock builds over 64 words,
  // then one ambiguous edge on the data phase drops lock.
  task automatic test_nominal_and_ambiguous();
    logic [3:0] w;
    reset_dut();
    for (int k = 1; k <= 65; k++) begin
      w = (k % 2 == 1) ? 4'b1100 : 4'b0011;
      drive(w);
      if (k >= 2) begin
        checks++;
        if (out_data !== (((k - 1) % 2 == 1) ? 2'b00 : 2'b01)) begin
          errors++; $display("FAIL nominal_data word %0d: got %b", k - 1, out_data);
        end
        checks++;
        if (out_phase !== 2'd0 || out_count !== 2'd1) begin
          errors++; $display("FAIL nominal_phase_count word %0d: got p=%0d c=%0d want p=0 c=1", k - 1, out_phase, out_count);
        end
        checks++;
        if (out_locked !== (k - 1 >= 64)) begin
          errors++; $display("FAIL nominal_lock word %0d: got %0b want %0b", k - 1, out_locked, (k - 1 >= 64));
        end
      end
    end
    drive(4'b0000);
    checks++;
    if (out_locked !== 1'b1) begin errors++; $display("FAIL locked_hold: got %0b want 1", out_locked); end
    drive(4'b0000);
    checks++;
    if (out_locked !== 1'b0) begin errors++; $display("FAIL ambiguous_lock_drop: got %0b want 0", out_locked); end
    checks++;
    if (out_phase !== 2'd0 || out_count !== 2'd1 || out_data !== 2'b00) begin
      errors++; $display("FAIL ambiguous_outputs: got p=%0d c=%0d d=%b want p=0 c=1 d=00", out_phase, out_count, out_data);
    end
    // Asynchronous reset mid-run takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_count !== 2'd0 || out_phase !== 2'd0 || out_locked !== 1'b0 || out_data !== 2'b00) begin
      errors++; $display("FAIL midrun_reset: got c=%0d p=%0d l=%0b d=%b want all 0", out_count, out_phase, out_locked, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_late_drift();
    logic [3:0] words [7] = '{4'b1000, 4'b0111, 4'b1000, 4'b0111, 4'b1000, 4'b0111, 4'b0000};
    logic [1:0] edata [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [1:0] ephase[6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      drive(words[k]);
      if (k > 0) begin
        checks++;
        if (out_phase !== ephase[k-1] || out_data !== edata[k-1] || out_count !== 2'd1) begin
          errors++; $display("FAIL late_drift word %0d: got p=%0d d=%b c=%0d want p=%0d d=%b c=1",
                             k, out_phase, out_data, out_count, ephase[k-1], edata[k-1]);
        end
      end
    end
  endtask

  // Early votes wrap p 0->3 (two bits out), then late votes wrap p 3->0 (none out).
  task automatic test_wraps();
    logic [3:0] words [11] = '{4'b1110, 4'b0001, 4'b1110, 4'b0001, 4'b1100, 4'b0011,
                               4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b0000};
    logic [1:0] ecount[10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    logic [1:0] edata [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    logic [1:0] ephase[10] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    reset_dut();
    for (int k = 0; k < 11; k++) begin
      drive(words[k]);
      if (k > 0) begin
        checks++;
        if (out_count !== ecount[k-1] || out_data !== edata[k-1] || out_phase !== ephase[k-1]) begin
          errors++; $display("FAIL wrap word %0d: got c=%0d d=%b p=%0d want c=%0d d=%b p=%0d",
                             k, out_count, out_data, out_phase, ecount[k-1], edata[k-1], ephase[k-1]);
        end
`ifdef ODR_SLIP_STATS_EN
        if (k == 5) begin
          checks++;
          if (out_dup_cnt !== 16'd1 || out_drop_cnt !== 16'd0) begin
            errors++; $display("FAIL dup_cnt: got dup=%0d drop=%0d want 1/0", out_dup_cnt, out_drop_cnt);
          end
        end
        if (k == 9) begin
          checks++;
          if (out_drop_cnt !== 16'd1 || out_dup_cnt !== 16'd1) begin
            errors++; $display("FAIL drop_cnt: got drop=%0d dup=%0d want 1/1", out_drop_cnt, out_dup_cnt);
          end
        end
`endif
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_samples = 4'b0000;
    test_reset();
    test_nominal_and_ambiguous();
    test_late_drift();
    test_wraps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
